// File: rtl/grey_pkg.sv
// Shared constants and helpers for the 5-bit single-bit-change decade code.
// Digit order G0..G9; one bit flips on every step, including G9 -> G0.
package grey_pkg;

   localparam int CODE_W = 5;

   localparam logic [CODE_W-1:0] G0 = 5'b00000;
   localparam logic [CODE_W-1:0] G1 = 5'b00001;
   localparam logic [CODE_W-1:0] G2 = 5'b00011;
   localparam logic [CODE_W-1:0] G3 = 5'b00010;
   localparam logic [CODE_W-1:0] G4 = 5'b00110;
   localparam logic [CODE_W-1:0] G5 = 5'b00100;
   localparam logic [CODE_W-1:0] G6 = 5'b01100;
   localparam logic [CODE_W-1:0] G7 = 5'b01000;
   localparam logic [CODE_W-1:0] G8 = 5'b11000;
   localparam logic [CODE_W-1:0] G9 = 5'b10000;

   // Invalid codes recover to G0 in either direction.
   function automatic logic [CODE_W-1:0] f_grey_next(input logic [CODE_W-1:0] code);
      case (code)
         G0:      return G1;
         G1:      return G2;
         G2:      return G3;
         G3:      return G4;
         G4:      return G5;
         G5:      return G6;
         G6:      return G7;
         G7:      return G8;
         G8:      return G9;
         default: return G0;
      endcase
   endfunction

   function automatic logic [CODE_W-1:0] f_grey_prev(input logic [CODE_W-1:0] code);
      case (code)
         G0:      return G9;
         G1:      return G0;
         G2:      return G1;
         G3:      return G2;
         G4:      return G3;
         G5:      return G4;
         G6:      return G5;
         G7:      return G6;
         G8:      return G7;
         G9:      return G8;
         default: return G0;
      endcase
   endfunction

   function automatic logic [3:0] f_grey_to_bcd(input logic [CODE_W-1:0] code);
      case (code)
         G0:      return 4'd0;
         G1:      return 4'd1;
         G2:      return 4'd2;
         G3:      return 4'd3;
         G4:      return 4'd4;
         G5:      return 4'd5;
         G6:      return 4'd6;
         G7:      return 4'd7;
         G8:      return 4'd8;
         G9:      return 4'd9;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic f_grey_is_term(input logic [CODE_W-1:0] code, input logic up);
      return up ? (code == G9) : (code == G0);
   endfunction

endpackage

// File: rtl/grey_digit.sv
// One decade digit: load / step up / step down / hold, with terminal-code flag
// that feeds the ripple-enable of the next digit.
module grey_digit
   import grey_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_step,
   input  logic              i_up,
   input  logic              i_load,
   input  logic [CODE_W-1:0] i_load_d,
   output logic [CODE_W-1:0] o_code,
   output logic              o_term
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_code <= G0;
      else if (i_load)
         o_code <= i_load_d;
      else if (i_step)
         o_code <= i_up ? f_grey_next(o_code) : f_grey_prev(o_code);
   end

   // Invalid codes never match G9/G0, so they block the ripple.
   assign o_term = f_grey_is_term(o_code, i_up);

endmodule

// File: rtl/grey_decade_counter.sv
// N-digit decade counter in the single-bit-change code, up/down, load, wrap pulse.
// Define GREY_BCD_OUT_EN to add the combinational o_bcd decode port.
module grey_decade_counter
   import grey_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_up,
   input  logic                       i_load,
   input  logic [CODE_W*DIGITS-1:0]   i_load_d,
   output logic [CODE_W*DIGITS-1:0]   o_count,
   output logic                       o_zero,
   output logic                       o_wrap
`ifdef GREY_BCD_OUT_EN
   ,
   output logic [4*DIGITS-1:0]        o_bcd
`endif
);

   logic [DIGITS:0]   step;
   logic [DIGITS-1:0] term;
   logic [DIGITS-1:0] is_zero;

   assign step[0] = i_en;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      grey_digit u_digit (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_step   (step[k]),
         .i_up     (i_up),
         .i_load   (i_load),
         .i_load_d (i_load_d[CODE_W*k +: CODE_W]),
         .o_code   (o_count[CODE_W*k +: CODE_W]),
         .o_term   (term[k])
      );

      assign step[k+1]  = step[k] & term[k];
      assign is_zero[k] = (o_count[CODE_W*k +: CODE_W] == G0);

`ifdef GREY_BCD_OUT_EN
      assign o_bcd[4*k +: 4] = f_grey_to_bcd(o_count[CODE_W*k +: CODE_W]);
`endif
   end

   assign o_zero = &is_zero;

   // Carry out of the top digit means every digit was terminal this edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_wrap <= 1'b0;
      else
         o_wrap <= ~i_load & step[DIGITS];
   end

endmodule

// File: tb/tb_grey_decade_counter.sv
// Scoreboard bench for grey_decade_counter: decimal-digit reference model,
// expected outputs queued by the driver and checked by an independent monitor.
module tb_grey_decade_counter;

   localparam int DIGITS = 2;
   localparam int W      = 5 * DIGITS;

   logic            i_clk;
   logic            i_rst;
   logic            i_en;
   logic            i_up;
   logic            i_load;
   logic [W-1:0]    i_load_d;
   logic [W-1:0]    o_count;
   logic            o_zero;
   logic            o_wrap;
   logic [4*DIGITS-1:0] o_bcd;

   grey_decade_counter #(.DIGITS(DIGITS)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (i_en),
      .i_up     (i_up),
      .i_load   (i_load),
      .i_load_d (i_load_d),
      .o_count  (o_count),
      .o_zero   (o_zero),
      .o_wrap   (o_wrap)
`ifdef GREY_BCD_OUT_EN
      ,
      .o_bcd    (o_bcd)
`endif
   );

`ifndef GREY_BCD_OUT_EN
   assign o_bcd = '0;
`endif

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [W-1:0]        count;
      logic                wrap;
      logic                zero;
      logic [4*DIGITS-1:0] bcd;
   } exp_t;

   exp_t        q[$];
   int          checks;
   int          errors;
   logic [4:0]  gtab[10];
   int          mval[DIGITS];   // decimal value 0..9, or -1 for an invalid code
   logic [4:0]  mraw[DIGITS];
   logic        mwrap;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int code_to_val(input logic [4:0] c);
      for (int i = 0; i < 10; i++)
         if (gtab[i] == c) return i;
      return -1;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.count = '0;
      e.bcd   = '0;
      e.zero  = 1'b1;
      e.wrap  = mwrap;
      for (int k = 0; k < DIGITS; k++) begin
         if (mval[k] < 0) begin
            e.count[5*k +: 5] = mraw[k];
            e.bcd[4*k +: 4]   = 4'hF;
            e.zero            = 1'b0;
         end else begin
            e.count[5*k +: 5] = gtab[mval[k]];
            e.bcd[4*k +: 4]   = 4'(mval[k]);
            if (mval[k] != 0) e.zero = 1'b0;
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DIGITS; k++) begin
         mval[k] = 0;
         mraw[k] = 5'b0;
      end
      mwrap = 1'b0;
   endtask

   task automatic model_step(input logic load, input logic en, input logic up,
                             input logic [W-1:0] d);
      int  term_val;
      bit  carry;
      bit  all_term;
      int  old;
      term_val = up ? 9 : 0;
      if (load) begin
         for (int k = 0; k < DIGITS; k++) begin
            mraw[k] = d[5*k +: 5];
            mval[k] = code_to_val(mraw[k]);
         end
         mwrap = 1'b0;
      end else if (en) begin
         all_term = 1'b1;
         for (int k = 0; k < DIGITS; k++)
            if (mval[k] != term_val) all_term = 1'b0;
         carry = 1'b1;
         for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
               old = mval[k];
               if (old < 0)    mval[k] = 0;
               else if (up)    mval[k] = (old + 1) % 10;
               else            mval[k] = (old + 9) % 10;
               carry = (old == term_val);
            end
         end
         mwrap = all_term;
      end else begin
         mwrap = 1'b0;
      end
   endtask

   task automatic drive(input logic load, input logic en, input logic up,
                        input logic [W-1:0] d);
      @(negedge i_clk);
      i_load   = load;
      i_en     = en;
      i_up     = up;
      i_load_d = d;
      model_step(load, en, up, d);
      q.push_back(model_out());
   endtask

   // Reset strictly between edges so the asynchronous path is what gets observed.
   task automatic do_reset();
      @(negedge i_clk);
      i_en   = 1'b0;
      i_load = 1'b0;
      #1 i_rst = 1'b1;
      #1;
      chk("rst_count", 64'(o_count), 64'(0));
      chk("rst_zero",  64'(o_zero),  64'(1));
      chk("rst_wrap",  64'(o_wrap),  64'(0));
      model_reset();
      #1 i_rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("count", 64'(o_count), 64'(e.count));
            chk("wrap",  64'(o_wrap),  64'(e.wrap));
            chk("zero",  64'(o_zero),  64'(e.zero));
`ifdef GREY_BCD_OUT_EN
            chk("bcd",   64'(o_bcd),   64'(e.bcd));
`endif
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [W-1:0] d;
      checks = 0;
      errors = 0;
      gtab[0] = 5'b00000; gtab[1] = 5'b00001; gtab[2] = 5'b00011; gtab[3] = 5'b00010;
      gtab[4] = 5'b00110; gtab[5] = 5'b00100; gtab[6] = 5'b01100; gtab[7] = 5'b01000;
      gtab[8] = 5'b11000; gtab[9] = 5'b10000;
      model_reset();
      i_rst = 1'b1; i_en = 1'b0; i_up = 1'b0; i_load = 1'b0; i_load_d = '0;
      #12 i_rst = 1'b0;

      do_reset();
      repeat (100) drive(1'b0, 1'b1, 1'b1, '0);
      drive(1'b0, 1'b0, 1'b1, '0);

      do_reset();
      drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);

      drive(1'b1, 1'b1, 1'b1, {gtab[4], gtab[7]});
      repeat (5) drive(1'b0, 1'b0, 1'($urandom), W'($urandom));

      drive(1'b1, 1'b0, 1'b0, {gtab[3], 5'b11111});
      drive(1'b0, 1'b1, 1'b1, '0);
      drive(1'b1, 1'b0, 1'b0, {gtab[3], 5'b11111});
      drive(1'b0, 1'b1, 1'b0, '0);

      drive(1'b1, 1'b0, 1'b1, {gtab[3], gtab[6]});
      drive(1'b0, 1'b1, 1'b1, '0);
      drive(1'b1, 1'b0, 1'b1, {gtab[3], 5'b10101});
      drive(1'b0, 1'b0, 1'b1, '0);

      drive(1'b1, 1'b0, 1'b1, {gtab[9], gtab[9]});
      drive(1'b0, 1'b1, 1'b1, '0);
      drive(1'b0, 1'b1, 1'b1, '0);
      repeat (7) drive(1'b0, 1'b1, 1'b0, '0);
      do_reset();
      drive(1'b0, 1'b0, 1'b0, '0);

      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < DIGITS; k++)
            d[5*k +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                      : gtab[$urandom_range(0, 9)];
         if ($urandom_range(0, 15) == 0)
            drive(1'b1, 1'($urandom), 1'($urandom), d);
         else
            drive(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), d);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      repeat (3) @(negedge i_clk);
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
